// File: rtl/multicycle_controller_if.sv
// Unified memory port handshake between the controller and memory.
// master: controller drives mem_req/mem_we; slave: memory drives mem_ready.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing,
// one shared memory port (mem.*), PC/IR strobes, retired-instruction count.
// Ports: clock, reset (async, active-low), run, op, func, zero, mem (master),
//   ir_write, pc_write, pc_src, reg_write, regdst, alusrc, memtoreg,
//   state, trap, mem_err, instr_count.
// Optional: MC_TIMEOUT_EN enables the memory-wait watchdog (sets mem_err).
module multicycle_controller #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [5:0]             op,
    input  logic [5:0]             func,
    input  logic                   zero,
    multicycle_controller_if.master mem,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic [1:0]             pc_src,
    output logic                   reg_write,
    output logic                   regdst,
    output logic                   alusrc,
    output logic                   memtoreg,
    output logic [2:0]             state,
    output logic                   trap,
    output logic                   mem_err,
    output logic [CNT_W-1:0]       instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR   = 6'h08;

    function automatic logic f_jr(input logic [5:0] o, input logic [5:0] f);
        return (o == OP_R) && (f == FN_JR);
    endfunction

    function automatic logic f_imm(input logic [5:0] o);
        return (o == OP_LW) || (o == OP_SW) || (o == OP_ADDI) || (o == OP_ORI);
    endfunction

    function automatic logic f_exec(input logic [5:0] o);
        return (o == OP_R) || (o == OP_BEQ) || f_imm(o);
    endfunction

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       func_q, func_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic             jmp_q, jmp_d;
    logic             br_q, br_d;
    logic [1:0]       pc_src_q, pc_src_d;
    logic             reg_write_q, reg_write_d;
    logic             regdst_q, regdst_d;
    logic             alusrc_q, alusrc_d;
    logic             memtoreg_q, memtoreg_d;
    logic             trap_q, trap_d;
    logic             hs;
    logic             fetch_done;
    logic             retire;
    logic             tmo_hit;

    // mem_ready only counts while a request is actually outstanding
    assign hs         = mem_req_q & mem.mem_ready;
    assign fetch_done = (state_q == S_FETCH) & hs;

`ifdef MC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_err_q;
    logic          wait_c;

    assign wait_c  = mem_req_q & ~mem.mem_ready;
    assign tmo_hit = wait_c & (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if ((state_d != state_q) || tmo_hit) begin
            tmo_d = '0;
        end else if (wait_c) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (tmo_hit) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign mem_err = mem_err_q;
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign mem_err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        func_d  = func_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (hs) begin
                    state_d = S_DECODE;
                    op_d    = op;
                    func_d  = func;
                end
            end
            S_DECODE: begin
                if ((op_q == OP_J) || f_jr(op_q, func_q)) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (f_exec(op_q)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BEQ) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (hs) begin
                    if (op_q == OP_SW) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // watchdog abort: drop the request, do not retire
        if (tmo_hit) begin
            state_d = S_FETCH;
            retire  = 1'b0;
        end
    end

    // Registered outputs are decoded from the state being entered,
    // so each strobe is valid for the whole cycle of that state.
    always_comb begin
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, retire};
        mem_req_d   = ((state_d == S_FETCH) & run) | (state_d == S_MEM);
        mem_we_d    = (state_d == S_MEM) & (op_d == OP_SW);
        jmp_d       = (state_d == S_DECODE) &
                      ((op_d == OP_J) | f_jr(op_d, func_d));
        br_d        = (state_d == S_EXEC) & (op_d == OP_BEQ);
        alusrc_d    = ((state_d == S_EXEC) | (state_d == S_MEM) |
                       (state_d == S_WB)) & f_imm(op_d);
        reg_write_d = (state_d == S_WB);
        regdst_d    = (state_d == S_WB) & (op_d == OP_R);
        memtoreg_d  = (state_d == S_WB) & (op_d == OP_LW);
        trap_d      = trap_q | (state_d == S_TRAP);
        pc_src_d    = 2'd0;
        if ((state_d == S_DECODE) && (op_d == OP_J)) begin
            pc_src_d = 2'd2;
        end else if ((state_d == S_DECODE) && f_jr(op_d, func_d)) begin
            pc_src_d = 2'd3;
        end else if (br_d) begin
            pc_src_d = 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            op_q        <= '0;
            func_q      <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            jmp_q       <= 1'b0;
            br_q        <= 1'b0;
            pc_src_q    <= 2'd0;
            reg_write_q <= 1'b0;
            regdst_q    <= 1'b0;
            alusrc_q    <= 1'b0;
            memtoreg_q  <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            func_q      <= func_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            jmp_q       <= jmp_d;
            br_q        <= br_d;
            pc_src_q    <= pc_src_d;
            reg_write_q <= reg_write_d;
            regdst_q    <= regdst_d;
            alusrc_q    <= alusrc_d;
            memtoreg_q  <= memtoreg_d;
            trap_q      <= trap_d;
        end
    end

    // fetch strobes coincide with the completing memory beat;
    // beq redirect follows the ALU zero flag computed in EXEC
    assign ir_write    = fetch_done;
    assign pc_write    = jmp_q | (br_q & zero) | fetch_done;
    assign pc_src      = pc_src_q;
    assign reg_write   = reg_write_q;
    assign regdst      = regdst_q;
    assign alusrc      = alusrc_q;
    assign memtoreg    = memtoreg_q;
    assign state       = state_q;
    assign trap        = trap_q;
    assign instr_count = cnt_q;
    assign mem.mem_req = mem_req_q;
    assign mem.mem_we  = mem_we_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction expected
// cycle traces built from the instruction rules, checked every cycle.
module tb_multicycle_controller;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b1;
    logic          zero = 1'b0;
    logic [5:0]    op = '0;
    logic [5:0]    func = '0;
    logic          ir_write, pc_write, reg_write, regdst, alusrc, memtoreg;
    logic [1:0]    pc_src;
    logic [2:0]    state;
    logic          trap, mem_err;
    logic [CW-1:0] instr_count;

    multicycle_controller_if mif();

    multicycle_controller #(.CNT_W(CW), .TIMEOUT_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .op          (op),
        .func        (func),
        .zero        (zero),
        .mem         (mif),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .regdst      (regdst),
        .alusrc      (alusrc),
        .memtoreg    (memtoreg),
        .state       (state),
        .trap        (trap),
        .mem_err     (mem_err),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       run, rdy, zero;
        bit [5:0] op, func;
        bit [2:0] st;
        bit       req, we, irw, pcw;
        bit [1:0] pcs;
        bit       rw, rd, as, m2r, trap, merr;
        int       cnt;
    } rec_t;

    rec_t     q[$];
    bit       last_run, cur_run, exp_trap, exp_merr;
    int       exp_cnt;
    bit [5:0] drv_op, drv_func;
    int       passed = 0;
    int       total = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        else
            passed++;
    endtask

    function automatic rec_t blank();
        rec_t r;
        r = '{default: 0};
        r.run  = cur_run;
        r.rdy  = 1'b1;
        r.zero = 1'b1;
        r.op   = drv_op;
        r.func = drv_func;
        return r;
    endfunction

    task automatic push(input rec_t r, input bit ret);
        r.cnt  = exp_cnt;
        r.trap = exp_trap;
        r.merr = exp_merr;
        q.push_back(r);
        last_run = r.run;
        if (ret) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    task automatic add_instr(input bit [5:0] o, input bit [5:0] f,
                             input bit z, input int fw, input int mw,
                             input bit drop, input bit partial,
                             input bit stuck);
        rec_t r;
        bit rt, lw, sw, bq, imm, legal;
        rt    = (o == 6'h00);
        lw    = (o == 6'h23);
        sw    = (o == 6'h2B);
        bq    = (o == 6'h04);
        imm   = lw | sw | (o == 6'h08) | (o == 6'h0D);
        legal = rt | bq | imm;
        drv_op   = o;
        drv_func = f;
        cur_run  = 1'b1;
        for (int i = 0; i < fw; i++) begin
            r = blank(); r.rdy = 1'b0; r.req = last_run;
            push(r, 1'b0);
        end
        r = blank(); r.req = 1'b1; r.irw = 1'b1; r.pcw = 1'b1;
        push(r, 1'b0);
        // memory data changes after fetch; the latched opcode must rule
        drv_op   = 6'h3F;
        drv_func = 6'h3F;
        if (drop) cur_run = 1'b0;
        r = blank(); r.st = 3'd1;
        if (o == 6'h02) begin
            r.pcw = 1'b1; r.pcs = 2'd2; push(r, 1'b1); return;
        end
        if (rt && f == 6'h08) begin
            r.pcw = 1'b1; r.pcs = 2'd3; push(r, 1'b1); return;
        end
        push(r, 1'b0);
        if (!legal) return;
        r = blank(); r.st = 3'd2; r.as = imm;
        if (bq) begin
            r.zero = z; r.pcw = z; r.pcs = 2'd1; push(r, 1'b1); return;
        end
        push(r, 1'b0);
        if (lw || sw) begin
            for (int i = 0; i < mw; i++) begin
                r = blank(); r.st = 3'd3; r.req = 1'b1; r.we = sw;
                r.as = 1'b1; r.rdy = 1'b0;
                push(r, 1'b0);
            end
            if (stuck) begin exp_merr = 1'b1; return; end
            if (partial) return;
            r = blank(); r.st = 3'd3; r.req = 1'b1; r.we = sw; r.as = 1'b1;
            push(r, sw);
            if (sw) return;
        end
        r = blank(); r.st = 3'd4; r.rw = 1'b1; r.rd = rt; r.m2r = lw;
        r.as = imm;
        push(r, 1'b1);
    endtask

    task automatic add_trap(input int n);
        rec_t r;
        exp_trap = 1'b1;
        for (int i = 0; i < n; i++) begin
            r = blank(); r.st = 3'd5;
            push(r, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            cur_run = (i == n - 1);
            r = blank(); r.req = last_run;
            push(r, 1'b0);
        end
    endtask

    task automatic run_trace();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clock);
            run           = r.run;
            mif.mem_ready = r.rdy;
            op            = r.op;
            func          = r.func;
            zero          = r.zero;
            #1;
            check("outs",
                  32'({state, mif.mem_req, mif.mem_we, ir_write, pc_write,
                       pc_src, reg_write, regdst, alusrc, memtoreg,
                       trap, mem_err}),
                  32'({r.st, r.req, r.we, r.irw, r.pcw, r.pcs, r.rw,
                       r.rd, r.as, r.m2r, r.trap, r.merr}));
            check("count", 32'(instr_count), 32'(r.cnt));
        end
    endtask

    task automatic model_reset();
        exp_cnt  = 0;
        exp_trap = 1'b0;
        exp_merr = 1'b0;
        last_run = 1'b1;
        cur_run  = 1'b1;
    endtask

    initial begin
        model_reset();
        mif.mem_ready = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_req", 32'(mif.mem_req), 32'd0);
        check("rst_strb", 32'({ir_write, pc_write, reg_write, trap,
                               mem_err, mif.mem_we}), 32'd0);
        check("rst_cnt", 32'(instr_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        reset = 1'b1;

        add_instr(6'h00, 6'h20, 0, 0, 0, 0, 0, 0);
        check("lat_R", 32'(q.size()), 32'd4);
        run_trace();
        @(posedge clock); #1;
        check("cnt_R", 32'(instr_count), 32'd1);

        add_instr(6'h23, 6'h00, 0, 1, 3, 0, 0, 0);
        check("lat_lw", 32'(q.size()), 32'd9);
        run_trace();
        add_instr(6'h2B, 6'h00, 0, 0, 0, 0, 0, 0);
        check("lat_sw", 32'(q.size()), 32'd4);
        run_trace();
        add_instr(6'h04, 6'h00, 1, 0, 0, 0, 0, 0);
        check("lat_beq", 32'(q.size()), 32'd3);
        add_instr(6'h04, 6'h00, 0, 0, 0, 0, 0, 0);
        add_instr(6'h02, 6'h00, 0, 0, 0, 0, 0, 0);
        check("lat_j", 32'(q.size()), 32'd8);
        add_instr(6'h00, 6'h08, 0, 0, 0, 0, 0, 0);
        add_instr(6'h08, 6'h00, 0, 0, 0, 0, 0, 0);
        add_instr(6'h0D, 6'h00, 0, 0, 0, 0, 0, 0);
        add_instr(6'h2B, 6'h00, 0, 0, 0, 1, 0, 0);
        idle(3);
        run_trace();

        for (int i = 0; i < 7; i++) add_instr(6'h02, 6'h00, 0, 0, 0, 0, 0, 0);
        run_trace();
        @(posedge clock); #1;
        check("cnt_wrap", 32'(instr_count), 32'd1);

        add_instr(6'h2B, 6'h00, 0, 1, 3, 0, 0, 0);
        add_instr(6'h23, 6'h00, 0, 0, 2, 0, 1, 0);
        run_trace();
        #2 reset = 1'b0;
        #1;
        check("mrst_req", 32'(mif.mem_req), 32'd0);
        check("mrst_strb", 32'({ir_write, pc_write, reg_write, memtoreg}),
              32'd0);
        check("mrst_st", 32'(state), 32'd0);
        check("mrst_cnt", 32'(instr_count), 32'd0);
        @(negedge clock);
        model_reset();
        run = 1'b1;
        reset = 1'b1;

`ifdef MC_TIMEOUT_EN
        add_instr(6'h2B, 6'h00, 0, 0, 4, 0, 0, 1);
        run_trace();
        check("tmo_err", 32'(mem_err), 32'd1);
        check("tmo_cnt", 32'(instr_count), 32'd0);
`endif

        add_instr(6'h3F, 6'h00, 0, 0, 0, 0, 0, 0);
        add_trap(5);
        run_trace();
        check("trap_st", 32'(state), 32'd5);
        check("trap_flag", 32'(trap), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
